axil_ram_slave: RTL and testbench

AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

---
 rtl/axil_pkg.sv | 8 +
 rtl/axil_ram_mem.sv | 42 ++++
 rtl/axil_ram_slave.sv | 93 +++++++++
 tb/tb_axil_ram_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants: response codes and default bus widths.
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         AXIL_DATA_WIDTH = 32;
  localparam int         AXIL_ADDR_WIDTH = 5;

endpackage

// File: rtl/axil_ram_mem.sv
// Byte-enabled RAM array: synchronous write, registered read port with async-cleared output.
module axil_ram_mem import axil_pkg::*; #(
  parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int WORD_AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [WORD_AW-1:0]    i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [STRB_WIDTH-1:0] i_wr_strb,
  input  logic                  i_rd_en,
  input  logic [WORD_AW-1:0]    i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2**WORD_AW;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (i_wr_strb[i]) r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite RAM slave: independent read/write handshakes in front of axil_ram_mem.
module axil_ram_slave import axil_pkg::*; #(
  parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
  parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_AW  = ADDR_WIDTH - ADDR_LSB;

  logic r_awready;
  logic r_wready;
  logic r_bvalid;
  logic r_arready;
  logic r_rvalid;
  logic w_wr_accept;
  logic w_rd_accept;
  logic w_unused;

  // The ready terms make each accept a one-cycle pulse, so a held request
  // cannot be accepted on back-to-back edges.
  assign w_wr_accept = s_axil_awvalid & s_axil_wvalid & (~r_bvalid | s_axil_bready)
                     & ~r_awready & ~r_wready;
  assign w_rd_accept = s_axil_arvalid & (~r_rvalid | s_axil_rready) & ~r_arready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_awready <= w_wr_accept;
      r_wready  <= w_wr_accept;
      r_arready <= w_rd_accept;
      if (w_wr_accept)        r_bvalid <= 1'b1;
      else if (s_axil_bready) r_bvalid <= 1'b0;
      if (w_rd_accept)        r_rvalid <= 1'b1;
      else if (s_axil_rready) r_rvalid <= 1'b0;
    end
  end

  axil_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .WORD_AW    (WORD_AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_accept),
    .i_wr_idx  (s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB]),
    .i_wr_data (s_axil_wdata),
    .i_wr_strb (s_axil_wstrb),
    .i_rd_en   (w_rd_accept),
    .i_rd_idx  (s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB]),
    .o_rd_data (s_axil_rdata)
  );

  // Protection bits and sub-word address bits carry no meaning for this RAM.
  assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = AXI_RESP_OKAY;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rresp   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed bench for axil_ram_slave: vector table of writes/reads plus backpressure and reset sequences.
module tb_axil_ram_slave;

  logic        clk;
  logic        rst;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  axil_ram_slave dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Idle write: accept expected on the first edge, bvalid cleared on the next (bready=1).
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!awready && n < 16);
    chk("wr_accept_cycles", n, 1);
    chk("wr_wready", wready, 1'b1);
    chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_bresp", bresp, 2'b00);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    chk("wr_awready_pulse", awready, 1'b0);
    chk("wr_bvalid_clear", bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!arready && n < 16);
    chk("rd_accept_cycles", n, 1);
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, exp);
    chk("rd_rresp", rresp, 2'b00);
    arvalid = 1'b0;
    @(posedge clk); #1;
    chk("rd_rvalid_clear", rvalid, 1'b0);
  endtask

  typedef struct {
    logic        is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  initial begin
    // For reads, data is the expected rdata.
    vecs[0]  = '{1'b1, 5'h01, 32'd2345,      4'hF};
    vecs[1]  = '{1'b0, 5'h01, 32'h0000_0929, 4'h0};
    vecs[2]  = '{1'b1, 5'h04, 32'hAABB_CCDD, 4'hF};
    vecs[3]  = '{1'b1, 5'h04, 32'h1122_3344, 4'b0101};
    vecs[4]  = '{1'b0, 5'h04, 32'hAA22_CC44, 4'h0};
    vecs[5]  = '{1'b1, 5'h03, 32'h0000_0055, 4'hF};
    vecs[6]  = '{1'b0, 5'h00, 32'h0000_0055, 4'h0};
    vecs[7]  = '{1'b1, 5'h1C, 32'hDEAD_BEEF, 4'hF};
    vecs[8]  = '{1'b0, 5'h1F, 32'hDEAD_BEEF, 4'h0};
    vecs[9]  = '{1'b1, 5'h08, 32'h0000_0000, 4'hF};
    vecs[10] = '{1'b1, 5'h09, 32'h1234_5678, 4'b1000};
    vecs[11] = '{1'b0, 5'h0A, 32'h1200_0000, 4'h0};
    vecs[12] = '{1'b1, 5'h08, 32'hFFFF_FFFF, 4'b0000};
    vecs[13] = '{1'b0, 5'h08, 32'h1200_0000, 4'h0};
    vecs[14] = '{1'b0, 5'h04, 32'hAA22_CC44, 4'h0};
    vecs[15] = '{1'b0, 5'h00, 32'h0000_0055, 4'h0};

    rst = 1'b0;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = 3'b101; arvalid = 1'b0; rready = 1'b0;
    #2;
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else               do_read(vecs[i].addr, vecs[i].data);
    end

    // Write backpressure: held request waits for bready.
    @(negedge clk);
    awaddr = 5'h14; wdata = 32'h0000_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    chk("bp_first_accept", awready, 1'b1);
    wdata = 32'h0000_BBBB;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("bp_no_accept", awready, 1'b0);
      chk("bp_bvalid_held", bvalid, 1'b1);
    end
    @(negedge clk);
    bready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_accept", awready, 1'b1);
    chk("bp_bvalid_kept", bvalid, 1'b1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    chk("bp_bvalid_clear", bvalid, 1'b0);
    do_read(5'h14, 32'h0000_BBBB);

    // Read backpressure: rdata stable, held arvalid waits for rready.
    do_write(5'h18, 32'h6666_6666, 4'hF);
    @(negedge clk);
    araddr = 5'h18; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    chk("rbp_first_accept", arready, 1'b1);
    araddr = 5'h04;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rbp_no_arready", arready, 1'b0);
      chk("rbp_rvalid_held", rvalid, 1'b1);
      chk("rbp_rdata_stable", rdata, 32'h6666_6666);
    end
    @(negedge clk);
    rready = 1'b1;
    @(posedge clk); #1;
    chk("rbp_second_accept", arready, 1'b1);
    chk("rbp_second_rvalid", rvalid, 1'b1);
    chk("rbp_second_rdata", rdata, 32'hAA22_CC44);
    arvalid = 1'b0;
    @(posedge clk); #1;
    chk("rbp_rvalid_clear", rvalid, 1'b0);

    // Same-word read and write on one edge returns the old data.
    do_write(5'h10, 32'h0F0F_0F0F, 4'hF);
    @(negedge clk);
    awaddr = 5'h10; wdata = 32'h0000_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 5'h12; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    chk("rw_same_wr_accept", awready, 1'b1);
    chk("rw_same_rd_accept", arready, 1'b1);
    chk("rw_same_old_data", rdata, 32'h0F0F_0F0F);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    do_read(5'h10, 32'h0000_1111);

    // Async reset with both responses pending.
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_bvalid", bvalid, 1'b1);
    chk("pre_rst_rvalid", rvalid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_awready", awready, 1'b0);
    chk("mid_rst_arready", arready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_read(5'h0C, 32'hCAFE_F00D);
    do_read(5'h04, 32'hAA22_CC44);
    do_read(5'h1C, 32'hDEAD_BEEF);
    do_read(5'h18, 32'h6666_6666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
